// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : Shared definitions for the multi-cycle MIPS control path:
//             opcode values, ALU operation codes, mux select codes, FSM
//             state encodings and the packed control-word bundle.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Primary opcodes recognised by the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation codes (zero-extended to the ALU op width at the port)
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_OR    = 3'd2;
    localparam logic [2:0] ALU_FUNCT = 3'd4;

    // PC source mux selects
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // ALU B operand mux selects
    localparam logic [1:0] ALUB_REG    = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH = 2'd3;

    // FSM states; encodings 13..15 are unreachable
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_RTYPE_WB = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ITYPE_WB = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // Datapath control word
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage
`default_nettype wire

// File: rtl/ctrl_opdecode.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_opdecode
//  Purpose  : Combinational opcode decoder. Maps an opcode to the state that
//             follows DECODE and flags opcodes that are not supported.
//  Ports    : op_i          - opcode field
//             next_state_o  - state to enter after DECODE
//             illegal_o     - opcode is not a supported instruction
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_opdecode
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W            = 6,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic [OP_W-1:0] op_i,
    output state_t          next_state_o,
    output logic            illegal_o
);

    localparam logic [OP_W-1:0] C_OP_RTYPE = OP_W'(OP_RTYPE);
    localparam logic [OP_W-1:0] C_OP_ORI   = OP_W'(OP_ORI);
    localparam logic [OP_W-1:0] C_OP_LW    = OP_W'(OP_LW);
    localparam logic [OP_W-1:0] C_OP_SW    = OP_W'(OP_SW);
    localparam logic [OP_W-1:0] C_OP_BEQ   = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] C_OP_J     = OP_W'(OP_J);

    always_comb begin
        next_state_o = S_FETCH;
        illegal_o    = 1'b0;
        case (op_i)
            C_OP_RTYPE:        next_state_o = S_EXEC_R;
            C_OP_ORI:          next_state_o = S_EXEC_I;
            C_OP_LW, C_OP_SW:  next_state_o = S_MEM_ADDR;
            C_OP_BEQ:          next_state_o = S_BRANCH;
            C_OP_J:            next_state_o = S_JUMP;
            default: begin
                illegal_o    = 1'b1;
                // Without trapping, an unknown opcode retires as a NOP
                next_state_o = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Multi-cycle MIPS main control FSM. Steps each instruction
//             through fetch/decode/execute/memory/writeback and drives the
//             shared datapath enables from the current state.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             op                - opcode from the instruction register
//             zero              - ALU zero flag (BEQ)
//             mem_ready         - memory access completes this cycle
//             pc_write .. alu_op- datapath controls
//             instr_done        - pulse on the last cycle of an instruction
//             illegal           - FSM parked in TRAP
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W            = 6,
    parameter int ALUOP_W         = 3,
    parameter bit MEM_WAIT_EN     = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done,
    output logic               illegal
);

    localparam logic [OP_W-1:0] C_OP_LW = OP_W'(OP_LW);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    state_t          dec_next;
    logic            dec_illegal;
    logic            mem_rdy;
    ctrl_t           ctrl;

    // With waiting disabled the memory is assumed to complete every cycle
    assign mem_rdy = mem_ready | ~MEM_WAIT_EN;

    ctrl_opdecode #(
        .OP_W            (OP_W),
        .TRAP_ON_ILLEGAL (TRAP_ON_ILLEGAL)
    ) u_opdecode (
        .op_i         (op),
        .next_state_o (dec_next),
        .illegal_o    (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ctrl    = CTRL_IDLE;

        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                if (mem_rdy) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_ALU;
                    state_d        = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                ctrl.alu_src_b  = ALUB_IMM_SH;
                ctrl.ext_op     = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                ctrl.instr_done = dec_illegal & ~TRAP_ON_ILLEGAL;
                op_d            = op;
                state_d         = dec_next;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALU_OR;
                state_d        = S_ITYPE_WB;
            end
            S_ITYPE_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.ext_op    = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                // Latched opcode: op may already show the next instruction
                state_d        = (op_q == C_OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_rdy) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_rdy) begin
                    ctrl.instr_done = 1'b1;
                    state_d         = S_FETCH;
                end
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = zero;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset suppresses every control so an aborted instruction writes nothing
        if (reset) begin
            ctrl = CTRL_IDLE;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign ext_op        = ctrl.ext_op;
    assign alu_op        = ALUOP_W'(ctrl.alu_op);
    assign instr_done    = ctrl.instr_done;
    assign illegal       = ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Self-checking bench for multicycle_control. Three instances:
//             0 = defaults, 1 = illegal opcodes retire as NOP,
//             2 = memory wait disabled with mem_ready tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_ORI   = 6'b001101;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_BAD   = 6'b111111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic zero = 1'b0;
    logic mem_ready = 1'b1;

    always #5 clk = ~clk;

    // Observed control words, one per instance
    logic [2:0][19:0] obs;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pcw, pcwc, iod, mr, mw, irw, m2r, rdst, rw, asa, ext, done, ill;
        logic [1:0] pcs, asb;
        logic [2:0] alu;
        multicycle_control #(
            .OP_W            (6),
            .ALUOP_W         (3),
            .MEM_WAIT_EN     (g != 2),
            .TRAP_ON_ILLEGAL (g != 1)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .op            (op),
            .zero          (zero),
            .mem_ready     ((g == 2) ? 1'b0 : mem_ready),
            .pc_write      (pcw),
            .pc_write_cond (pcwc),
            .pc_source     (pcs),
            .i_or_d        (iod),
            .mem_read      (mr),
            .mem_write     (mw),
            .ir_write      (irw),
            .mem_to_reg    (m2r),
            .reg_dst       (rdst),
            .reg_write     (rw),
            .alu_src_a     (asa),
            .alu_src_b     (asb),
            .ext_op        (ext),
            .alu_op        (alu),
            .instr_done    (done),
            .illegal       (ill)
        );
        assign obs[g] = {pcw, pcwc, pcs, iod, mr, mw, irw, m2r, rdst, rw,
                         asa, asb, ext, alu, done, ill};
    end

    function automatic logic [19:0] ow(
        input logic pcw, input logic pcwc, input logic [1:0] pcs,
        input logic iod, input logic mr, input logic mw, input logic irw,
        input logic m2r, input logic rdst, input logic rw, input logic asa,
        input logic [1:0] asb, input logic ext, input logic [2:0] alu,
        input logic done, input logic ill);
        return {pcw, pcwc, pcs, iod, mr, mw, irw, m2r, rdst, rw, asa, asb, ext, alu, done, ill};
    endfunction

    // Expected control words per state, written from the state table
    logic [19:0] e_idle, e_fgo, e_fwait, e_dec, e_dec_nop, e_exr, e_rwb, e_exi, e_iwb;
    logic [19:0] e_madr, e_mrd, e_mwb, e_mwr_wait, e_mwr_go, e_br1, e_br0, e_jmp, e_trap;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    typedef struct {
        string       tag;
        int          dut;
        logic [19:0] exp;
    } sb_t;
    sb_t sb[$];

    // Drive one cycle of stimulus just after the edge and queue its expectation
    task automatic drive(input string tag, input int dut, input logic r, input logic [5:0] o,
                         input logic z, input logic m, input logic [19:0] e);
        sb_t item;
        @(posedge clk);
        #1;
        reset     = r;
        op        = o;
        zero      = z;
        mem_ready = m;
        item.tag  = tag;
        item.dut  = dut;
        item.exp  = e;
        sb.push_back(item);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t item;
            item = sb.pop_front();
            check(item.tag, 32'(obs[item.dut]), 32'(item.exp));
        end
    end

    initial begin
        //              pcw  pcwc pcs   iod  mr   mw   irw  m2r  rdst rw   asa  asb   ext  alu   done ill
        e_idle     = '0;
        e_fgo      = ow(1'b1,1'b0,2'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,3'd0,1'b0,1'b0);
        e_fwait    = ow(1'b0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,3'd0,1'b0,1'b0);
        e_dec      = ow(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b1,3'd0,1'b0,1'b0);
        e_dec_nop  = ow(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b1,3'd0,1'b1,1'b0);
        e_exr      = ow(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,3'd4,1'b0,1'b0);
        e_rwb      = ow(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,1'b0,3'd0,1'b1,1'b0);
        e_exi      = ow(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,1'b0,3'd2,1'b0,1'b0);
        e_iwb      = ow(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,1'b0,3'd0,1'b1,1'b0);
        e_madr     = ow(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,1'b1,3'd0,1'b0,1'b0);
        e_mrd      = ow(1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,3'd0,1'b0,1'b0);
        e_mwb      = ow(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,1'b0,3'd0,1'b1,1'b0);
        e_mwr_wait = ow(1'b0,1'b0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,3'd0,1'b0,1'b0);
        e_mwr_go   = ow(1'b0,1'b0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,3'd0,1'b1,1'b0);
        e_br1      = ow(1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,3'd1,1'b1,1'b0);
        e_br0      = ow(1'b0,1'b0,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,3'd1,1'b1,1'b0);
        e_jmp      = ow(1'b1,1'b0,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,3'd0,1'b1,1'b0);
        e_trap     = ow(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,3'd0,1'b0,1'b1);

        // Reset for two cycles, then an R-type instruction
        drive("rst_c1",   0, 1'b1, T_RTYPE, 1'b0, 1'b1, e_idle);
        drive("rst_c2",   0, 1'b1, T_RTYPE, 1'b0, 1'b1, e_idle);
        drive("r_fetch",  0, 1'b0, T_RTYPE, 1'b0, 1'b1, e_fgo);
        drive("r_decode", 0, 1'b0, T_RTYPE, 1'b0, 1'b1, e_dec);
        drive("r_exec",   0, 1'b0, T_RTYPE, 1'b0, 1'b1, e_exr);
        drive("r_wb",     0, 1'b0, T_RTYPE, 1'b0, 1'b1, e_rwb);

        // LW with two wait cycles in MEM_RD (7 cycles total)
        drive("lw_fetch", 0, 1'b0, T_LW, 1'b0, 1'b1, e_fgo);
        drive("lw_dec",   0, 1'b0, T_LW, 1'b0, 1'b1, e_dec);
        drive("lw_addr",  0, 1'b0, T_LW, 1'b0, 1'b1, e_madr);
        drive("lw_rd_w1", 0, 1'b0, T_LW, 1'b0, 1'b0, e_mrd);
        drive("lw_rd_w2", 0, 1'b0, T_LW, 1'b0, 1'b0, e_mrd);
        drive("lw_rd_go", 0, 1'b0, T_LW, 1'b0, 1'b1, e_mrd);
        drive("lw_wb",    0, 1'b0, T_LW, 1'b0, 1'b1, e_mwb);

        // BEQ taken then not taken
        drive("beq1_fetch", 0, 1'b0, T_BEQ, 1'b1, 1'b1, e_fgo);
        drive("beq1_dec",   0, 1'b0, T_BEQ, 1'b1, 1'b1, e_dec);
        drive("beq1_br",    0, 1'b0, T_BEQ, 1'b1, 1'b1, e_br1);
        drive("beq0_fetch", 0, 1'b0, T_BEQ, 1'b0, 1'b1, e_fgo);
        drive("beq0_dec",   0, 1'b0, T_BEQ, 1'b0, 1'b1, e_dec);
        drive("beq0_br",    0, 1'b0, T_BEQ, 1'b0, 1'b1, e_br0);

        // Fetch stall, then SW with op switched to J after DECODE
        drive("sw_fwait", 0, 1'b0, T_SW, 1'b0, 1'b0, e_fwait);
        drive("sw_fetch", 0, 1'b0, T_SW, 1'b0, 1'b1, e_fgo);
        drive("sw_dec",   0, 1'b0, T_SW, 1'b0, 1'b1, e_dec);
        drive("sw_addr",  0, 1'b0, T_J,  1'b0, 1'b1, e_madr);
        drive("sw_wr_w",  0, 1'b0, T_J,  1'b0, 1'b0, e_mwr_wait);
        drive("sw_wr_go", 0, 1'b0, T_J,  1'b0, 1'b1, e_mwr_go);

        // Jump, then ORI
        drive("j_fetch",   0, 1'b0, T_J,   1'b0, 1'b1, e_fgo);
        drive("j_dec",     0, 1'b0, T_J,   1'b0, 1'b1, e_dec);
        drive("j_jump",    0, 1'b0, T_J,   1'b0, 1'b1, e_jmp);
        drive("ori_fetch", 0, 1'b0, T_ORI, 1'b0, 1'b1, e_fgo);
        drive("ori_dec",   0, 1'b0, T_ORI, 1'b0, 1'b1, e_dec);
        drive("ori_exec",  0, 1'b0, T_ORI, 1'b0, 1'b1, e_exi);
        drive("ori_wb",    0, 1'b0, T_ORI, 1'b0, 1'b1, e_iwb);

        // Illegal opcode traps until reset
        drive("ill_fetch", 0, 1'b0, T_BAD, 1'b0, 1'b1, e_fgo);
        drive("ill_dec",   0, 1'b0, T_BAD, 1'b0, 1'b1, e_dec);
        for (int i = 0; i < 12; i++) begin
            drive("ill_trap", 0, 1'b0, (i % 2 == 0) ? T_RTYPE : T_BAD, 1'b0, 1'(i % 3 != 0), e_trap);
        end
        drive("ill_rst",   0, 1'b1, T_RTYPE, 1'b0, 1'b1, e_idle);
        drive("ill_refet", 0, 1'b0, T_RTYPE, 1'b0, 1'b1, e_fgo);

        // Illegal opcode retires as a NOP when trapping is disabled
        drive("nop_rst",   1, 1'b1, T_RTYPE, 1'b0, 1'b1, e_idle);
        drive("nop_fetch", 1, 1'b0, T_BAD,   1'b0, 1'b1, e_fgo);
        drive("nop_dec",   1, 1'b0, T_BAD,   1'b0, 1'b1, e_dec_nop);
        drive("nop_refet", 1, 1'b0, T_RTYPE, 1'b0, 1'b1, e_fgo);

        // Memory wait disabled, mem_ready tied low
        drive("nw_rst",     2, 1'b1, T_ORI, 1'b0, 1'b0, e_idle);
        drive("nw_fetch",   2, 1'b0, T_ORI, 1'b0, 1'b0, e_fgo);
        drive("nw_dec",     2, 1'b0, T_ORI, 1'b0, 1'b0, e_dec);
        drive("nw_exec",    2, 1'b0, T_ORI, 1'b0, 1'b0, e_exi);
        drive("nw_wb",      2, 1'b0, T_ORI, 1'b0, 1'b0, e_iwb);
        drive("nwlw_fetch", 2, 1'b0, T_LW,  1'b0, 1'b0, e_fgo);
        drive("nwlw_dec",   2, 1'b0, T_LW,  1'b0, 1'b0, e_dec);
        drive("nwlw_addr",  2, 1'b0, T_LW,  1'b0, 1'b0, e_madr);
        drive("nwlw_rd",    2, 1'b0, T_LW,  1'b0, 1'b0, e_mrd);
        drive("nwlw_wb",    2, 1'b0, T_LW,  1'b0, 1'b0, e_mwb);
        drive("nw2_fetch",  2, 1'b0, T_ORI, 1'b0, 1'b0, e_fgo);
        drive("nw2_dec",    2, 1'b0, T_ORI, 1'b0, 1'b0, e_dec);
        drive("nw2_abort",  2, 1'b1, T_ORI, 1'b0, 1'b0, e_idle);
        drive("nw2_refet",  2, 1'b0, T_ORI, 1'b0, 1'b0, e_fgo);

        repeat (2) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
